// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for a Y86-style core: stage enables, status, perf counters.
// Define SEQ_CTRL_PERF_EN to build the cycle and retired-instruction counters.
module seq_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  icode_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        mem_ack_i,
  input  logic        dmem_error_i,
  output logic        f_en_o,
  output logic        d_en_o,
  output logic        e_en_o,
  output logic        w_en_o,
  output logic        pc_en_o,
  output logic        mem_req_o,
  output logic        set_cc_o,
  output logic [2:0]  stat_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
    S_WB, S_PCUP, S_HALT, S_FAULT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] icode_q, icode_d;
  logic [2:0] stat_q, stat_d;
  logic       mem_op;

  assign mem_op = (icode_q == IRMMOVQ) || (icode_q == IMRMOVQ) ||
                  (icode_q == ICALL)   || (icode_q == IRET)    ||
                  (icode_q == IPUSHQ)  || (icode_q == IPOPQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      icode_q <= INOP;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    stat_d  = stat_q;
    case (state_q)
      S_FETCH: begin
        icode_d = icode_i;
        if (imem_error_i) begin
          state_d = S_FAULT;
          stat_d  = SADR;
        end else if (!instr_valid_i) begin
          state_d = S_FAULT;
          stat_d  = SINS;
        end else if (icode_i == IHALT) begin
          state_d = S_HALT;
          stat_d  = SHLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = mem_op ? S_MEMORY : S_WB;
      S_MEMORY: begin
        if (mem_ack_i) begin
          if (dmem_error_i) begin
            state_d = S_FAULT;
            stat_d  = SADR;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB:    state_d = S_PCUP;
      S_PCUP:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Reset gates every strobe combinationally so a pending request drops at once.
  always_comb begin
    f_en_o    = 1'b0;
    d_en_o    = 1'b0;
    e_en_o    = 1'b0;
    w_en_o    = 1'b0;
    pc_en_o   = 1'b0;
    mem_req_o = 1'b0;
    set_cc_o  = 1'b0;
    if (!rst_i) begin
      f_en_o    = (state_q == S_FETCH);
      d_en_o    = (state_q == S_DECODE);
      e_en_o    = (state_q == S_EXECUTE);
      w_en_o    = (state_q == S_WB);
      pc_en_o   = (state_q == S_PCUP);
      mem_req_o = (state_q == S_MEMORY);
      set_cc_o  = (state_q == S_EXECUTE) && (icode_q == IOPQ);
    end
  end

  assign stat_o = stat_q;

`ifdef SEQ_CTRL_PERF_EN
  logic [63:0] cyc_q, cyc_d;
  logic [63:0] ir_q, ir_d;

  assign cyc_d = cyc_q + 64'd1;
  assign ir_d  = (state_q == S_PCUP) ? ir_q + 64'd1 : ir_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      ir_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      ir_q  <= ir_d;
    end
  end

  assign cycle_cnt_o = cyc_q;
  assign instret_o   = ir_q;
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif

endmodule
